// File: rtl/rgb_stream_converter.sv
// Streaming RGB colour-depth converter: per-channel truncate / round-with-saturation /
// MSB-replication, behind a registered output stage with a one-entry skid buffer.

module rgb_chan_conv #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 5,
    parameter int ROUND_EN = 1
) (
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] out_val,
    output logic             sat
);
    generate
        if (OUT_W == IN_W) begin : g_pass
            assign out_val = in_val;
            assign sat     = 1'b0;
        end else if (OUT_W < IN_W) begin : g_narrow
            if (ROUND_EN != 0) begin : g_round
                localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (IN_W - OUT_W - 1);
                logic [IN_W:0] sum;
                logic          unused_lsbs;
                assign sum         = {1'b0, in_val} + HALF;
                assign sat         = sum[IN_W];
                assign out_val     = sum[IN_W] ? {OUT_W{1'b1}} : sum[IN_W-1 -: OUT_W];
                assign unused_lsbs = ^sum[IN_W-OUT_W-1:0];
            end else begin : g_trunc
                logic unused_lsbs;
                assign out_val     = in_val[IN_W-1 -: OUT_W];
                assign sat         = 1'b0;
                assign unused_lsbs = ^in_val[IN_W-OUT_W-1:0];
            end
        end else begin : g_widen
            // Repeat the input MSB-first until the output is filled.
            for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
                assign out_val[OUT_W-1-gi] = in_val[IN_W-1-(gi % IN_W)];
            end
            assign sat = 1'b0;
        end
    endgenerate
endmodule

module rgb_stream_converter #(
    parameter int IN_R_W   = 8,
    parameter int IN_G_W   = 8,
    parameter int IN_B_W   = 8,
    parameter int OUT_R_W  = 5,
    parameter int OUT_G_W  = 6,
    parameter int OUT_B_W  = 5,
    parameter int ROUND_EN = 1,
    parameter int CNT_W    = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [IN_R_W+IN_G_W+IN_B_W-1:0] i_data,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic                           i_last,
    input  logic                           i_user,
    input  logic                           i_swap_rb,
    output logic [OUT_R_W-1:0]             o_red,
    output logic [OUT_G_W-1:0]             o_green,
    output logic [OUT_B_W-1:0]             o_blue,
    output logic [OUT_R_W+OUT_G_W+OUT_B_W-1:0] o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_last,
    output logic                           o_user,
    input  logic                           i_clear_stats,
    output logic [CNT_W-1:0]               o_sat_count
);
    localparam int IN_W  = IN_R_W + IN_G_W + IN_B_W;
    localparam int OUT_W = OUT_R_W + OUT_G_W + OUT_B_W;
    // Payload layout: {red, green, blue, any_sat, last, user}
    localparam int PL_W  = OUT_W + 3;

    logic [IN_R_W-1:0]  r_in;
    logic [IN_G_W-1:0]  g_in;
    logic [IN_B_W-1:0]  b_in;
    logic [OUT_R_W-1:0] r_out;
    logic [OUT_G_W-1:0] g_out;
    logic [OUT_B_W-1:0] b_out;
    logic               r_sat, g_sat, b_sat;
    logic [PL_W-1:0]    conv_pl;

    assign g_in = i_data[IN_G_W+IN_B_W-1 -: IN_G_W];

    generate
        if (IN_R_W == IN_B_W) begin : g_swap
            assign r_in = i_swap_rb ? i_data[IN_B_W-1:0] : i_data[IN_W-1 -: IN_R_W];
            assign b_in = i_swap_rb ? i_data[IN_W-1 -: IN_R_W] : i_data[IN_B_W-1:0];
        end else begin : g_no_swap
            logic unused_swap;
            assign r_in        = i_data[IN_W-1 -: IN_R_W];
            assign b_in        = i_data[IN_B_W-1:0];
            assign unused_swap = i_swap_rb;
        end
    endgenerate

    rgb_chan_conv #(.IN_W(IN_R_W), .OUT_W(OUT_R_W), .ROUND_EN(ROUND_EN)) u_conv_r (
        .in_val(r_in), .out_val(r_out), .sat(r_sat));
    rgb_chan_conv #(.IN_W(IN_G_W), .OUT_W(OUT_G_W), .ROUND_EN(ROUND_EN)) u_conv_g (
        .in_val(g_in), .out_val(g_out), .sat(g_sat));
    rgb_chan_conv #(.IN_W(IN_B_W), .OUT_W(OUT_B_W), .ROUND_EN(ROUND_EN)) u_conv_b (
        .in_val(b_in), .out_val(b_out), .sat(b_sat));

    assign conv_pl = {r_out, g_out, b_out, r_sat | g_sat | b_sat, i_last, i_user};

    logic              out_valid_q, out_valid_d;
    logic [PL_W-1:0]   out_pl_q, out_pl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [PL_W-1:0]   skid_pl_q, skid_pl_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;
    logic              in_xfer, out_xfer;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pl_d     = out_pl_q;
        skid_valid_d = skid_valid_q;
        skid_pl_d    = skid_pl_q;
        sat_cnt_d    = sat_cnt_q;
        in_xfer      = i_valid & ready_q;
        out_xfer     = out_valid_q & i_ready;

        if (!out_valid_q || i_ready) begin
            // Skid contents are older than anything arriving now, so they go first.
            if (skid_valid_q) begin
                out_pl_d     = skid_pl_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_pl_d    = conv_pl;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_pl_d    = conv_pl;
            skid_valid_d = 1'b1;
        end

        ready_d = !skid_valid_d;

        if (i_clear_stats) begin
            sat_cnt_d = '0;
        end else if (out_xfer && out_pl_q[2] && (sat_cnt_q != {CNT_W{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_pl_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_pl_q    <= '0;
            ready_q      <= 1'b0;
            sat_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pl_q     <= out_pl_d;
            skid_valid_q <= skid_valid_d;
            skid_pl_q    <= skid_pl_d;
            ready_q      <= ready_d;
            sat_cnt_q    <= sat_cnt_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = out_valid_q;
    assign o_data      = out_pl_q[PL_W-1 -: OUT_W];
    assign o_red       = out_pl_q[PL_W-1 -: OUT_R_W];
    assign o_green     = out_pl_q[OUT_G_W+OUT_B_W+2 -: OUT_G_W];
    assign o_blue      = out_pl_q[OUT_B_W+2 -: OUT_B_W];
    assign o_last      = out_pl_q[1];
    assign o_user      = out_pl_q[0];
    assign o_sat_count = sat_cnt_q;
endmodule

// File: tb/tb_rgb_stream_converter.sv
// Directed bench for rgb_stream_converter: truncating, rounding (2-bit counter) and
// widening instances share one clock and reset.

module tb_rgb_stream_converter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Instance A: defaults, truncate
    logic [23:0] a_data;  logic a_valid, a_last, a_user, a_swap, a_ready, a_clear;
    logic a_o_ready, a_o_valid, a_o_last, a_o_user;
    logic [4:0] a_o_red, a_o_blue; logic [5:0] a_o_green; logic [15:0] a_o_data, a_o_sat;

    // Instance B: defaults, round, CNT_W=2
    logic [23:0] b_data;  logic b_valid, b_last, b_user, b_swap, b_ready, b_clear;
    logic b_o_ready, b_o_valid, b_o_last, b_o_user;
    logic [4:0] b_o_red, b_o_blue; logic [5:0] b_o_green; logic [15:0] b_o_data; logic [1:0] b_o_sat;

    // Instance C: 5-bit to 8-bit widening
    logic [14:0] c_data;  logic c_valid, c_last, c_user, c_swap, c_ready, c_clear;
    logic c_o_ready, c_o_valid, c_o_last, c_o_user;
    logic [7:0] c_o_red, c_o_green, c_o_blue; logic [23:0] c_o_data; logic [15:0] c_o_sat;

    rgb_stream_converter #(.ROUND_EN(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_data(a_data), .i_valid(a_valid), .o_ready(a_o_ready),
        .i_last(a_last), .i_user(a_user), .i_swap_rb(a_swap), .o_red(a_o_red),
        .o_green(a_o_green), .o_blue(a_o_blue), .o_data(a_o_data), .o_valid(a_o_valid),
        .i_ready(a_ready), .o_last(a_o_last), .o_user(a_o_user), .i_clear_stats(a_clear),
        .o_sat_count(a_o_sat));

    rgb_stream_converter #(.ROUND_EN(1), .CNT_W(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_valid(b_valid), .o_ready(b_o_ready),
        .i_last(b_last), .i_user(b_user), .i_swap_rb(b_swap), .o_red(b_o_red),
        .o_green(b_o_green), .o_blue(b_o_blue), .o_data(b_o_data), .o_valid(b_o_valid),
        .i_ready(b_ready), .o_last(b_o_last), .o_user(b_o_user), .i_clear_stats(b_clear),
        .o_sat_count(b_o_sat));

    rgb_stream_converter #(.IN_R_W(5), .IN_G_W(5), .IN_B_W(5), .OUT_R_W(8), .OUT_G_W(8),
                           .OUT_B_W(8), .ROUND_EN(0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_data(c_data), .i_valid(c_valid), .o_ready(c_o_ready),
        .i_last(c_last), .i_user(c_user), .i_swap_rb(c_swap), .o_red(c_o_red),
        .o_green(c_o_green), .o_blue(c_o_blue), .o_data(c_o_data), .o_valid(c_o_valid),
        .i_ready(c_ready), .o_last(c_o_last), .o_user(c_o_user), .i_clear_stats(c_clear),
        .o_sat_count(c_o_sat));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are read at that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int sent, emitted, occ;
    logic acc, outx, hold;

    initial begin
        a_data = '0; a_valid = 0; a_last = 0; a_user = 0; a_swap = 0; a_ready = 1; a_clear = 0;
        b_data = '0; b_valid = 0; b_last = 0; b_user = 0; b_swap = 0; b_ready = 1; b_clear = 0;
        c_data = '0; c_valid = 0; c_last = 0; c_user = 0; c_swap = 0; c_ready = 1; c_clear = 0;

        step(); step();
        check("rst_a_ready", 32'(a_o_ready), 32'h0);
        check("rst_a_valid", 32'(a_o_valid), 32'h0);
        check("rst_b_ready", 32'(b_o_ready), 32'h0);
        rst = 0;
        step();
        check("post_rst_a_ready", 32'(a_o_ready), 32'h1);
        check("post_rst_a_valid", 32'(a_o_valid), 32'h0);
        check("post_rst_a_data", 32'(a_o_data), 32'h0);
        check("post_rst_a_side", 32'({a_o_last, a_o_user}), 32'h0);
        check("post_rst_a_cnt", 32'(a_o_sat), 32'h0);
        check("post_rst_b_cnt", 32'(b_o_sat), 32'h0);

        // Truncation
        a_valid = 1; a_data = 24'hFF8040;
        step();
        a_valid = 0;
        check("trunc_valid", 32'(a_o_valid), 32'h1);
        check("trunc_red", 32'(a_o_red), 32'h1F);
        check("trunc_green", 32'(a_o_green), 32'h20);
        check("trunc_blue", 32'(a_o_blue), 32'h08);
        check("trunc_data", 32'(a_o_data), 32'hFC08);
        step();
        check("trunc_drain", 32'(a_o_valid), 32'h0);

        // Swap plus sideband, then the same data unswapped
        a_valid = 1; a_data = 24'h112233; a_swap = 1; a_last = 1; a_user = 1;
        step();
        a_swap = 0; a_last = 0; a_user = 1;
        check("swap_red", 32'(a_o_red), 32'h06);
        check("swap_green", 32'(a_o_green), 32'h08);
        check("swap_blue", 32'(a_o_blue), 32'h02);
        check("swap_side", 32'({a_o_last, a_o_user}), 32'h3);
        step();
        a_valid = 0; a_user = 0;
        check("noswap_red", 32'(a_o_red), 32'h02);
        check("noswap_blue", 32'(a_o_blue), 32'h06);
        check("noswap_side", 32'({a_o_last, a_o_user}), 32'h1);
        step();

        // Back-pressure: pixel k carries red=k, i_ready pattern 1,0,0
        sent = 0; emitted = 0;
        for (int cyc = 0; cyc < 60 && emitted < 8; cyc++) begin
            a_valid = (sent < 8);
            a_data  = {5'(sent), 19'h0};
            a_ready = (cyc % 3 == 0);
            acc  = a_valid & a_o_ready;
            outx = a_o_valid & a_ready;
            hold = a_o_valid & !a_ready;
            if (outx) begin
                check("bp_order", 32'(a_o_data), 32'(emitted << 11));
                emitted++;
            end
            if (acc) sent++;
            step();
            if (hold) check("bp_hold", 32'({a_o_valid, a_o_data}), 32'h10000 | 32'(emitted << 11));
            occ = sent - emitted;
            check("bp_ready", 32'(a_o_ready), 32'(occ < 2));
            check("bp_valid", 32'(a_o_valid), 32'(occ > 0));
        end
        a_valid = 0; a_ready = 1;
        check("bp_count", 32'(emitted), 32'd8);
        step();

        // Widening
        c_valid = 1; c_data = 15'b10110_00001_11111;
        step();
        c_valid = 0;
        check("wide_red", 32'(c_o_red), 32'hB5);
        check("wide_green", 32'(c_o_green), 32'h08);
        check("wide_blue", 32'(c_o_blue), 32'hFF);
        check("wide_data", 32'(c_o_data), 32'hB508FF);
        check("wide_cnt", 32'(c_o_sat), 32'h0);

        // Rounding and saturation
        b_valid = 1; b_data = 24'h0C0606;
        step();
        b_data = 24'hFCFEFC;
        check("round_rgb", 32'({b_o_red, b_o_green, b_o_blue}), 32'({5'h02, 6'h02, 5'h01}));
        step();
        b_valid = 0;
        check("sat_data", 32'(b_o_data), 32'hFFFF);
        check("sat_cnt_pre", 32'(b_o_sat), 32'h0);
        step();
        check("sat_cnt_1", 32'(b_o_sat), 32'h1);
        b_valid = 1;
        repeat (4) step();
        b_valid = 0;
        step(); step();
        check("sat_cnt_hold", 32'(b_o_sat), 32'h3);

        // Clear coinciding with a saturating transfer
        b_valid = 1;
        step();
        b_valid = 0; b_clear = 1;
        step();
        b_clear = 0;
        check("clear_wins", 32'(b_o_sat), 32'h0);
        b_valid = 1;
        step();
        b_valid = 0;
        step();
        check("cnt_after_clear", 32'(b_o_sat), 32'h1);

        // Reset with both output and skid registers full
        b_ready = 0; b_valid = 1; b_data = 24'h0C0606;
        step();
        b_data = 24'hFCFEFC;
        step();
        b_valid = 0;
        check("skid_full_ready", 32'(b_o_ready), 32'h0);
        rst = 1;
        step();
        check("midrst_valid", 32'(b_o_valid), 32'h0);
        check("midrst_ready", 32'(b_o_ready), 32'h0);
        rst = 0; b_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_stale", 32'(b_o_valid), 32'h0);
        end
        check("midrst_cnt", 32'(b_o_sat), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/rgb_stream_converter.md
Name: rgb_stream_converter

Overview:
Parametrised streaming colour-depth converter for the video path. It takes packed RGB pixels on a valid/ready stream and resizes each channel independently to a configurable output width, using truncation or round-to-nearest with saturation. Results are presented both per channel and packed. A registered skid buffer decouples the upstream ready from downstream back-pressure, and a saturation counter supports display-path diagnostics.

Parameters:
IN_R_W, 8, input red width (1..16)
IN_G_W, 8, input green width (1..16)
IN_B_W, 8, input blue width (1..16)
OUT_R_W, 5, output red width (1..16)
OUT_G_W, 6, output green width (1..16)
OUT_B_W, 5, output blue width (1..16)
ROUND_EN, 1, 1 = round-to-nearest with saturation, 0 = truncate
CNT_W, 16, width of saturation counter

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_data  in  IN_R_W+IN_G_W+IN_B_W  packed pixel {R,G,B}, red in MSBs
i_valid  in  1  input pixel valid
o_ready  out  1  converter can accept a pixel (registered)
i_last  in  1  end-of-line marker, travels with pixel
i_user  in  1  start-of-frame marker, travels with pixel
i_swap_rb  in  1  per-pixel: swap R and B inputs before conversion (BGR source); requires IN_R_W==IN_B_W and is ignored otherwise
o_red  out  OUT_R_W  converted red
o_green  out  OUT_G_W  converted green
o_blue  out  OUT_B_W  converted blue
o_data  out  OUT_R_W+OUT_G_W+OUT_B_W  packed {o_red,o_green,o_blue}
o_valid  out  1  output pixel valid
i_ready  in  1  downstream accepts output
o_last  out  1  registered copy of i_last
o_user  out  1  registered copy of i_user
i_clear_stats  in  1  synchronous clear of o_sat_count
o_sat_count  out  CNT_W  number of output pixels with at least one saturated channel; saturates at all-ones

Behaviour:
- Transfer in = i_valid & o_ready. Transfer out = o_valid & i_ready.
- Reset values:
  - o_valid=0, o_ready=0 during reset, and 1 on the first cycle after reset.
  - o_red/o_green/o_blue/o_data=0, o_last=0, o_user=0, o_sat_count=0.
  - Skid buffer empty.
- Latency: an accepted pixel appears on the outputs the next cycle when the output register is empty or being drained. Throughput is 1 pixel/clock with i_ready held high.
- Skid buffer:
  - Main output register plus one skid register.
  - If input is accepted while the output is held (o_valid & !i_ready), the pixel goes to the skid register and o_ready drops next cycle.
  - When the output drains, the skid register moves to the output and o_ready reasserts.
  - Pixels are never dropped or duplicated. Order is preserved.
  - o_data and sideband stay stable while o_valid & !i_ready.
- Per-channel conversion, with N = IN width and M = OUT width:
  - M == N: pass through.
  - M < N, truncate: out = in[N-1 -: M].
  - M < N, round: s = in + 2^(N-M-1), computed in N+1 bits. If s[N] is set, out = all-ones and the channel is flagged saturated; otherwise out = s[N-1 -: M].
  - M > N: MSB replication, out = {in, in[N-1 -: M-N]} repeated as needed to fill M bits. For example, 5-bit 10110 to 8 bits gives 10110101. Never saturates.
- Swap: when i_swap_rb=1 and the widths allow it, the R and B fields of i_data are exchanged before conversion. Output ordering is unchanged.
- o_sat_count:
  - Increments by 1 on each output transfer whose pixel had any saturated channel. Holds at 2^CNT_W-1.
  - When i_clear_stats and an increment coincide, clear wins and the count is 0.
- Reset mid-frame: pending pixels are discarded, all state returns to reset values, and no partial pixel is emitted.
- o_last and o_user are never modified by conversion.

Test Plan:
- Defaults, ROUND_EN=0, i_ready=1: i_data=24'hFF8040 -> o_red=5'h1F, o_green=6'h20, o_blue=5'h08, o_data=16'hFC08, one cycle after acceptance.
- Defaults, ROUND_EN=1: 24'h0C0606 -> R=5'h02, G=6'h02, B=5'h01. 24'hFCFEFC -> R=5'h1F (sat), G=6'h3F (sat), B=5'h1F (sat), and o_sat_count increments to 1.
- Back-pressure: stream 8 pixels 0..7 while toggling i_ready 1,0,0,1,… -> all 8 emitted in order with no loss or duplicates, o_ready low only while the skid register is full, and outputs stable during stalls.
- Widening, IN_*_W=5, OUT_*_W=8: i_data=15'b10110_00001_11111 -> o_red=8'hB5, o_green=8'h08, o_blue=8'hFF.
- i_swap_rb=1, 24'h112233, truncate -> o_red=5'h06, o_blue=5'h02. o_last and o_user follow their pixel exactly.
- Counter: CNT_W=2, drive 5 saturating pixels -> count reaches 3 and holds. Assert i_clear_stats on the same cycle as a saturating transfer -> count is 0. Asserting i_rst mid-stream -> o_valid=0 next cycle and no stale pixels emitted afterwards.
